acq_command_sequencer: RTL

- Top-level controller for the acoustics capture path. It decodes single-byte UART commands and sequences one capture of SAMPLE_COUNT ADC samples into the sample buffer.
- It owns the buffer's single address port, sharing it between the capture writer and the dump reader. It streams captured samples back over the UART transmitter.
- Sits between the UART rx/tx, the ADC front end (data_logging/data_ready) and the sample RAM.

---
 rtl/acq_ctrl_pkg.sv | 41 ++++
 rtl/acq_command_sequencer_if.sv | 27 ++
 rtl/uart_tx_byte_sender.sv | 74 +++++++
 rtl/acq_command_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/acq_ctrl_pkg.sv
// Shared definitions for the acquisition command sequencer: state encodings,
// command byte codes and the fixed reply bytes.
package acq_ctrl_pkg;

    // Top-level sequencer states; the encoding is exported on state_debug.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_SEND_HI = 3'd4,
        ST_SEND_LO = 3'd5,
        ST_STATUS  = 3'd6,
        ST_DRAIN   = 3'd7
    } acq_state_t;

    // Byte sender handshake states.
    typedef enum logic [2:0] {
        TX_IDLE       = 3'd0,
        TX_WAIT_READY = 3'd1,
        TX_PULSE      = 3'd2,
        TX_GUARD      = 3'd3,
        TX_WAIT_DONE  = 3'd4
    } tx_state_t;

    localparam logic [7:0] CMD_START_CODE  = 8'h53;  // 'S'
    localparam logic [7:0] CMD_DUMP_CODE   = 8'h44;  // 'D'
    localparam logic [7:0] CMD_ABORT_CODE  = 8'h41;  // 'A'
    localparam logic [7:0] CMD_STATUS_CODE = 8'h3F;  // '?'

    localparam logic [7:0] ERROR_BYTE    = 8'h45;    // 'E': dump requested with no capture
    localparam logic [4:0] STATUS_PREFIX = 5'b10100;

    // Status reply: fixed prefix, then capture_valid, data_logging, busy at command time.
    function automatic logic [7:0] status_byte(input logic capture_valid,
                                               input logic data_logging,
                                               input logic busy_prev);
        return {STATUS_PREFIX, capture_valid, data_logging, busy_prev};
    endfunction

endpackage

// File: rtl/acq_command_sequencer_if.sv
// UART, ADC-control and sample-buffer signals seen by the sequencer.
interface acq_command_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              rx_ready;
    logic [7:0]        rx_data;
    logic              tx_ready;
    logic              tx_send;
    logic [7:0]        tx_data;
    logic              data_ready;
    logic              data_logging;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [15:0]       buf_rdata;

    // Sequencer side.
    modport master (
        input  rx_ready, rx_data, tx_ready, data_ready, buf_rdata,
        output tx_send, tx_data, data_logging, buf_we, buf_addr
    );

    // Peripheral side (UART, ADC front end, sample RAM).
    modport slave (
        output rx_ready, rx_data, tx_ready, data_ready, buf_rdata,
        input  tx_send, tx_data, data_logging, buf_we, buf_addr
    );
endinterface

// File: rtl/uart_tx_byte_sender.sv
// Sends one byte over the UART transmitter handshake: wait for tx_ready,
// pulse tx_send, ignore tx_ready while the transmitter reacts, then report
// done once tx_ready is seen again. A byte not yet handed over can be cancelled.
module uart_tx_byte_sender
    import acq_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cancel,
    input  logic [7:0] send_byte,
    input  logic       tx_ready,
    output logic       tx_send,
    output logic [7:0] tx_data,
    output logic       done,
    output logic       in_flight,
    output logic       busy
);

    tx_state_t  state_reg;
    logic [7:0] byte_reg;
    logic       tx_send_reg;
    logic [7:0] tx_data_reg;
    logic       done_reg;

    // Handshake sequencing; tx_data only changes together with a tx_send pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= TX_IDLE;
            byte_reg    <= '0;
            tx_send_reg <= 1'b0;
            tx_data_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            tx_send_reg <= 1'b0;
            done_reg    <= 1'b0;
            case (state_reg)
                TX_IDLE: begin
                    if (start && !cancel) begin
                        byte_reg  <= send_byte;
                        state_reg <= TX_WAIT_READY;
                    end
                end
                TX_WAIT_READY: begin
                    if (cancel) begin
                        state_reg <= TX_IDLE;
                    end else if (tx_ready) begin
                        tx_send_reg <= 1'b1;
                        tx_data_reg <= byte_reg;
                        state_reg   <= TX_PULSE;
                    end
                end
                // tx_ready may still read high while the pulse is being accepted.
                TX_PULSE:     state_reg <= TX_GUARD;
                TX_GUARD:     state_reg <= TX_WAIT_DONE;
                TX_WAIT_DONE: begin
                    if (tx_ready) begin
                        done_reg  <= 1'b1;
                        state_reg <= TX_IDLE;
                    end
                end
                default:      state_reg <= TX_IDLE;
            endcase
        end
    end

    assign tx_send   = tx_send_reg;
    assign tx_data   = tx_data_reg;
    assign done      = done_reg;
    assign busy      = (state_reg != TX_IDLE);
    assign in_flight = (state_reg == TX_PULSE) || (state_reg == TX_GUARD) ||
                       (state_reg == TX_WAIT_DONE);

endmodule

// File: rtl/acq_command_sequencer.sv
// Command decoder and capture/dump sequencer for the acoustics capture path.
// Owns the sample buffer address port and streams captured words MSB first.
module acq_command_sequencer
    import acq_ctrl_pkg::*;
#(
    parameter int         SAMPLE_COUNT = 1024,
    parameter int         ADDR_W       = 10,
    parameter logic [7:0] CMD_START    = CMD_START_CODE,
    parameter logic [7:0] CMD_DUMP     = CMD_DUMP_CODE,
    parameter logic [7:0] CMD_ABORT    = CMD_ABORT_CODE,
    parameter logic [7:0] CMD_STATUS   = CMD_STATUS_CODE
) (
    input  logic                           clk,
    input  logic                           reset,
    acq_command_sequencer_if.master        bus,
    output logic                           capture_valid,
    output logic                           busy,
    output logic [2:0]                     state_debug
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(SAMPLE_COUNT - 1);

    acq_state_t        state_reg;
    logic [ADDR_W-1:0] index_reg;
    logic [7:0]        word_lo_reg;
    logic              capture_valid_reg;
    logic              data_logging_reg;
    logic              buf_we_reg;
    logic [ADDR_W-1:0] buf_addr_reg;
    logic              tx_start_reg;
    logic [7:0]        tx_byte_reg;

    logic tx_done;
    logic tx_in_flight;
    logic tx_busy;
    logic tx_send_w;
    logic [7:0] tx_data_w;

    logic busy_now;
    logic rx_start;
    logic rx_dump;
    logic rx_abort;
    logic rx_status;
    logic abort_now;

    assign busy_now  = (state_reg != ST_IDLE);
    assign rx_start  = bus.rx_ready && (bus.rx_data == CMD_START);
    assign rx_dump   = bus.rx_ready && (bus.rx_data == CMD_DUMP);
    assign rx_abort  = bus.rx_ready && (bus.rx_data == CMD_ABORT);
    assign rx_status = bus.rx_ready && (bus.rx_data == CMD_STATUS);
    assign abort_now = busy_now && rx_abort;

    uart_tx_byte_sender u_sender (
        .clk       (clk),
        .reset     (reset),
        .start     (tx_start_reg),
        .cancel    (abort_now),
        .send_byte (tx_byte_reg),
        .tx_ready  (bus.tx_ready),
        .tx_send   (tx_send_w),
        .tx_data   (tx_data_w),
        .done      (tx_done),
        .in_flight (tx_in_flight),
        .busy      (tx_busy)
    );

    // Main sequencer; abort has priority over every other event in a busy state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            index_reg         <= '0;
            word_lo_reg       <= '0;
            capture_valid_reg <= 1'b0;
            data_logging_reg  <= 1'b0;
            buf_we_reg        <= 1'b0;
            buf_addr_reg      <= '0;
            tx_start_reg      <= 1'b0;
            tx_byte_reg       <= '0;
        end else begin
            buf_we_reg   <= 1'b0;
            tx_start_reg <= 1'b0;
            if (abort_now) begin
                data_logging_reg <= 1'b0;
                state_reg        <= tx_in_flight ? ST_DRAIN : ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (rx_start) begin
                            capture_valid_reg <= 1'b0;
                            data_logging_reg  <= 1'b1;
                            index_reg         <= '0;
                            state_reg         <= ST_CAPTURE;
                        end else if (rx_dump && capture_valid_reg) begin
                            index_reg    <= '0;
                            buf_addr_reg <= '0;
                            state_reg    <= ST_RD_ADDR;
                        end else if (rx_dump) begin
                            tx_byte_reg  <= ERROR_BYTE;
                            tx_start_reg <= 1'b1;
                            state_reg    <= ST_STATUS;
                        end else if (rx_status) begin
                            tx_byte_reg  <= status_byte(capture_valid_reg, data_logging_reg, busy_now);
                            tx_start_reg <= 1'b1;
                            state_reg    <= ST_STATUS;
                        end
                    end
                    ST_CAPTURE: begin
                        // data_logging already low means the final write happened last cycle.
                        if (!data_logging_reg) begin
                            capture_valid_reg <= 1'b1;
                            state_reg         <= ST_IDLE;
                        end else if (bus.data_ready) begin
                            buf_we_reg   <= 1'b1;
                            buf_addr_reg <= index_reg;
                            index_reg    <= index_reg + 1'b1;
                            if (index_reg == LAST_INDEX) begin
                                data_logging_reg <= 1'b0;
                            end
                        end
                    end
                    ST_RD_ADDR: state_reg <= ST_RD_WAIT;
                    ST_RD_WAIT: begin
                        word_lo_reg  <= bus.buf_rdata[7:0];
                        tx_byte_reg  <= bus.buf_rdata[15:8];
                        tx_start_reg <= 1'b1;
                        state_reg    <= ST_SEND_HI;
                    end
                    ST_SEND_HI: begin
                        if (tx_done) begin
                            tx_byte_reg  <= word_lo_reg;
                            tx_start_reg <= 1'b1;
                            state_reg    <= ST_SEND_LO;
                        end
                    end
                    ST_SEND_LO: begin
                        if (tx_done) begin
                            if (index_reg == LAST_INDEX) begin
                                state_reg <= ST_IDLE;
                            end else begin
                                index_reg    <= index_reg + 1'b1;
                                buf_addr_reg <= index_reg + 1'b1;
                                state_reg    <= ST_RD_ADDR;
                            end
                        end
                    end
                    ST_STATUS: begin
                        if (tx_done) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    ST_DRAIN: begin
                        if (!tx_busy) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.tx_send      = tx_send_w;
    assign bus.tx_data      = tx_data_w;
    assign bus.data_logging = data_logging_reg;
    assign bus.buf_we       = buf_we_reg;
    assign bus.buf_addr     = buf_addr_reg;
    assign capture_valid    = capture_valid_reg;
    assign busy             = busy_now;
    assign state_debug      = state_reg;

endmodule
